// File: rtl/inst_fetch_unit.sv
// Instruction fetch: PC, credit-limited imem requests, in-order response buffer,
// valid/ready delivery to decode, and redirect flush of stale in-flight reads.
module inst_fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [4:0]      inst_opcode,
  output logic            inst_illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

  typedef enum logic {FETCH, FLUSH} state_t;

  state_t          state, state_nx;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   in_flight;
  logic [CW-1:0]   drop, drop_nx;
  logic            live;
  logic [AW-1:0]   head, tail;
  logic [31:0]     buf_data [DEPTH];
  logic [XLEN-1:0] buf_pc [DEPTH];

  logic            accept, push, pop;
  logic [CW:0]     used;
  logic [XLEN-1:0] target;

  assign target = redirect_pc & ~(XLEN'(3));

  assign inst_valid   = (count != '0);
  assign inst_data    = buf_data[head];
  assign inst_pc      = buf_pc[head];
  assign inst_opcode  = inst_data[6:2];
  assign inst_illegal = (inst_data[1:0] != 2'b11);

  assign pop  = inst_valid & inst_ready & ~redirect_valid;
  assign push = (state == FETCH) & imem_rsp_valid & ~redirect_valid;

  // A same-cycle pop frees a slot, which keeps a full-rate stream going
  assign used = {1'b0, count} + {1'b0, in_flight}
              - {{CW{1'b0}}, pop};

  assign imem_addr      = pc;
  assign imem_req_valid = live & (state == FETCH)
                        & ~redirect_valid & (used < CAP);
  assign accept = imem_req_valid & imem_req_ready;

  always_comb begin
    state_nx = state;
    drop_nx  = drop;
    priority case (1'b1)
      redirect_valid: begin
        drop_nx  = in_flight - CW'(imem_rsp_valid);
        state_nx = (drop_nx != '0) ? FLUSH : FETCH;
      end
      (state == FLUSH) && imem_rsp_valid: begin
        drop_nx  = drop - CW'(1);
        state_nx = (drop_nx == '0) ? FETCH : FLUSH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      rsp_pc    <= RESET_PC;
      count     <= '0;
      in_flight <= '0;
      drop      <= '0;
      live      <= 1'b0;
      head      <= '0;
      tail      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else begin
      state     <= state_nx;
      drop      <= drop_nx;
      live      <= 1'b1;
      in_flight <= in_flight + CW'(accept) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        pc     <= target;
        rsp_pc <= target;
        count  <= '0;
        head   <= '0;
        tail   <= '0;
      end else begin
        if (accept)
          pc <= pc + XLEN'(4);
        if (push) begin
          buf_data[tail] <= imem_rsp_data;
          buf_pc[tail]   <= rsp_pc;
          tail           <= tail + AW'(1);
          rsp_pc         <= rsp_pc + XLEN'(4);
        end
        if (pop)
          head <= head + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
      if (imem_rsp_valid)
        assert (in_flight != '0);
      if (push && !pop)
        assert (count < CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: random-latency memory model plus
// an expected sequential PC stream restarted on every reset/redirect.
module tb_inst_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
  logic [4:0]  inst_opcode;
  logic        inst_illegal;

  always #5 clk = ~clk;

  inst_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_opcode(inst_opcode), .inst_illegal(inst_illegal)
  );

  int errors = 0, checks = 0;
  int rdy_pct = 100, ird_pct = 100, lat_min = 1, lat_max = 1;
  bit redir_req = 0;
  logic [31:0] redir_target = '0;
  int cyc = 0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] acc_addr[$];
  logic [31:0] exp_q[$];
  logic [31:0] fill_pc = RST_PC;
  int n_acc = 0, n_pop = 0, n_collide = 0;
  bit prev_rst = 0, prev_redir = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    logic [31:0] w;
    if (a == 32'h40) return 32'h0000_0013;
    if (a == 32'h44) return 32'h0000_0012;
    w = (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
    w[1:0] = (a[4:2] == 3'd5) ? 2'b10 : 2'b11;
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: memory responses, ready knobs, redirects
  always @(negedge clk) begin
    cyc++;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    inst_ready     = ($urandom_range(99) < ird_pct);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (!rst) begin
      mq_addr.delete();
      mq_due.delete();
    end else if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    redirect_valid = redir_req;
    redirect_pc    = redir_target;
    redir_req      = 0;
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [31:0] pe, we;
    #2;
    if (!rst) begin
      exp_q.delete();
      fill_pc    = RST_PC;
      prev_rst   = 1;
      prev_redir = 0;
    end else begin
      if (prev_rst) begin
        chk("rst_inst_valid", 32'(inst_valid), 0);
        chk("rst_req_valid", 32'(imem_req_valid), 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_inst_data", inst_data, 0);
        chk("rst_addr", imem_addr, RST_PC);
      end
      if (prev_redir)
        chk("post_redir_inst_valid", 32'(inst_valid), 0);
      prev_rst = 0;
      if (imem_req_valid)
        chk("addr_align", 32'(imem_addr[1:0]), 0);
      if (imem_req_valid && imem_req_ready) begin
        mq_addr.push_back(imem_addr);
        mq_due.push_back(cyc + $urandom_range(lat_max, lat_min));
        acc_addr.push_back(imem_addr);
        n_acc++;
      end
      if (redirect_valid) begin
        chk("redir_req_valid", 32'(imem_req_valid), 0);
        if (imem_rsp_valid && inst_valid && inst_ready)
          n_collide++;
        exp_q.delete();
        fill_pc = redirect_pc & ~32'h3;
      end else if (inst_valid && inst_ready) begin
        while (exp_q.size() < 4) begin
          exp_q.push_back(fill_pc);
          fill_pc += 4;
        end
        pe = exp_q.pop_front();
        we = word(pe);
        chk("inst_pc", inst_pc, pe);
        chk("inst_data", inst_data, we);
        chk("inst_opcode", 32'(inst_opcode), 32'(we[6:2]));
        chk("inst_illegal", 32'(inst_illegal), 32'(we[1:0] != 2'b11));
        if (pe == 32'h40) begin
          chk("addi_opcode", 32'(inst_opcode), 32'h04);
          chk("addi_legal", 32'(inst_illegal), 0);
        end
        if (pe == 32'h44)
          chk("illegal_word", 32'(inst_illegal), 1);
        n_pop++;
      end
      prev_redir = redirect_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    tick(n);
    rst = 1'b1;
  endtask

  task automatic wait_inflight2(input string name);
    int i;
    for (i = 0; i < 50 && mq_addr.size() != 2; i++)
      tick(1);
    chk(name, 32'(mq_addr.size()), 2);
  endtask

  task automatic redirect(input logic [31:0] t);
    redir_target = t;
    redir_req    = 1;
  endtask

  initial begin
    int i, idx;
    tick(1);
    // streaming at full rate
    do_reset(3);
    n_pop = 0;
    tick(20);
    chk("stream_rate", 32'(n_pop), 17);

    // decode stall: credit limit
    ird_pct = 0;
    do_reset(2);
    acc_addr.delete();
    n_acc = 0;
    tick(10);
    chk("stall_accepts", 32'(n_acc), 2);
    chk("stall_req_valid", 32'(imem_req_valid), 0);
    chk("stall_head_pc", inst_pc, 32'h0);
    ird_pct = 100;
    tick(6);
    chk("stall_next_addr", acc_addr.size() > 2 ? acc_addr[2] : 32'hdead, 32'h8);

    // redirect while two reads are outstanding
    lat_min = 3; lat_max = 3;
    tick(4);
    wait_inflight2("flush_setup");
    redirect(32'h103);
    tick(1);
    for (i = 0; i < 40 && !inst_valid; i++)
      tick(1);
    chk("flush_first_pc", inst_pc, 32'h100);
    tick(10);

    // redirect colliding with a response and a pop
    lat_min = 1; lat_max = 1;
    tick(8);
    redirect(32'h40);
    tick(12);
    chk("collide_seen", 32'(n_collide > 0), 1);

    // PC wrap
    idx = acc_addr.size();
    redirect(32'hFFFF_FFF8);
    tick(10);
    chk("wrap0", acc_addr.size() > idx ? acc_addr[idx] : 32'hdead,
        32'hFFFF_FFF8);
    chk("wrap1", acc_addr.size() > idx + 1 ? acc_addr[idx+1] : 32'hdead,
        32'hFFFF_FFFC);
    chk("wrap2", acc_addr.size() > idx + 2 ? acc_addr[idx+2] : 32'hdead,
        32'h0);

    // reset with reads in flight
    lat_min = 3; lat_max = 3;
    redirect(32'h40);
    tick(3);
    wait_inflight2("midrst_setup");
    do_reset(1);
    tick(5);

    // randomized traffic
    rdy_pct = 70; ird_pct = 60; lat_min = 1; lat_max = 4;
    for (i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 3)
        redirect($urandom_range(1, 0) ? $urandom : $urandom_range(255));
      if ($urandom_range(999) < 2)
        do_reset(1);
      else
        tick(1);
    end
    chk("random_progress", 32'(n_pop > 500), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
